axis_udp_packer: RTL and testbench
==================================

AXIS_UDP_PACKER -- requirements
Module: axis_udp_packer

Interface
REQ-001 The block SHALL expose parameter DATA_NUM, default 1024, meaning packet payload length in bytes (1..2**ADDR_WIDTH).
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 11, meaning buffer depth of 2**ADDR_WIDTH bytes.
REQ-003 The block SHALL provide: clk  in  1  sole clock, all logic rising-edge.
REQ-004 The block SHALL provide: resetn  in  1  asynchronous active-low reset.
REQ-005 The block SHALL provide: s_axis_tdata  in  8  upstream byte.
REQ-006 The block SHALL provide: s_axis_tvalid  in  1 / s_axis_tready  out  1  upstream handshake.
REQ-007 The block SHALL provide: m_axis_tdata  out  8  payload byte to eth_mac.
REQ-008 The block SHALL provide: m_axis_tvalid  out  1 / m_axis_tready  in  1  downstream handshake.
REQ-009 The block SHALL provide: m_axis_tuser  out  1 (first byte of packet) and m_axis_tlast  out  1 (last byte of packet).
REQ-010 The block SHALL provide: fifo_level  out  ADDR_WIDTH+1  buffered byte count.
REQ-011 The block SHALL provide: pkt_sent  out  16  completed-packet counter.

Function
REQ-012 Input handshake occurs when s_axis_tvalid and s_axis_tready are both 1; the byte is written at the write pointer, which then increments modulo 2**ADDR_WIDTH.
REQ-013 s_axis_tready SHALL be 1 exactly when fifo_level < 2**ADDR_WIDTH; no byte is ever dropped or overwritten.
REQ-014 fifo_level SHALL rise by 1 per write, fall by 1 per read, and stay unchanged on a simultaneous write and read in the same cycle.
REQ-015 The output FSM SHALL have states IDLE, LOAD, SEND.
REQ-016 IDLE -> LOAD when fifo_level >= DATA_NUM; LOAD issues the first RAM read; LOAD -> SEND unconditionally after one cycle.
REQ-017 m_axis_tvalid SHALL assert exactly 2 cycles after the input handshake that brings fifo_level to DATA_NUM, starting from IDLE.
REQ-018 In SEND, m_axis_tvalid SHALL stay 1 and m_axis_tdata/tuser/tlast SHALL stay stable until m_axis_tready is 1 (AXIS rule); the packet has no internal valid gaps.
REQ-019 A beat counter 0..DATA_NUM-1 SHALL drive tuser=1 on beat 0 only and tlast=1 on beat DATA_NUM-1 only; DATA_NUM=1 sets both on the single beat.
REQ-020 After the tlast handshake, the FSM SHALL return to IDLE, with m_axis_tvalid=0 for at least one cycle, and pkt_sent SHALL increment and wrap from 65535 to 0.
REQ-021 Bytes SHALL leave in arrival order; the read pointer wraps modulo 2**ADDR_WIDTH.
REQ-022 Input acceptance SHALL continue during SEND; a full buffer only deasserts s_axis_tready.

Reset
REQ-023 While resetn=0: pointers, fifo_level, beat counter, and pkt_sent SHALL be 0; FSM SHALL be IDLE; m_axis_tvalid/tuser/tlast SHALL be 0; m_axis_tdata SHALL be 8'h00; s_axis_tready SHALL be 0.
REQ-024 Reset mid-packet SHALL abandon the packet without emitting tlast; buffered data SHALL be discarded.
REQ-025 s_axis_tready SHALL return to 1 on the first clk edge after resetn deasserts.

Structure
REQ-026 FSM state encodings and the default DATA_NUM and ADDR_WIDTH constants SHALL reside in the shared eth package/header used by eth_mac.
REQ-027 Buffer storage SHALL be one sub-module, sdp_ram: a simple dual-port RAM with 8-bit width, 2**ADDR_WIDTH depth, and a registered 1-cycle read.
REQ-028 The implementation SHALL have no combinational path from m_axis_tready to s_axis_tready.

Verification (bench parameters DATA_NUM=8, ADDR_WIDTH=4)
REQ-029 The bench SHALL cover: write 8'h00..8'h07 back-to-back with m_axis_tready=1 -> tvalid 2 cycles after the 8th write, 8 contiguous beats 00..07, tuser on 00, tlast on 07, pkt_sent=1.
REQ-030 The bench SHALL cover: write 7 bytes only -> m_axis_tvalid stays 0 and fifo_level=7 indefinitely.
REQ-031 The bench SHALL cover: m_axis_tready=0, write 20 bytes -> s_axis_tready drops after the 16th, fifo_level=16, and releasing tready yields two packets 00..07 and 08..0F.
REQ-032 The bench SHALL cover: toggle m_axis_tready randomly during a packet -> data/tuser/tlast stable while stalled, exactly 8 beats, order preserved.
REQ-033 The bench SHALL cover: continuous input of 40 bytes with simultaneous read/write -> 5 packets in order, pointers wrap at 16, fifo_level consistent every cycle.
REQ-034 The bench SHALL cover: assert resetn=0 at beat 3 -> all outputs reset, no tlast, and the next 8 writes produce a fresh packet with tuser on its first byte.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet-path definitions: packer FSM encoding and default sizing.
package eth_pkg;

  localparam int unsigned ETH_DATA_NUM   = 1024;
  localparam int unsigned ETH_ADDR_WIDTH = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } pk_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module sdp_ram
  import eth_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ETH_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  // Storage array write; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // One-cycle registered read; holds its value when not enabled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    rd_data <= 8'h00;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_udp_packer.sv
// Buffers an upstream AXI-Stream byte flow and emits fixed-length packets
// (tuser on first byte, tlast on last byte) toward eth_mac.
module axis_udp_packer
  import eth_pkg::*;
#(
  parameter int unsigned DATA_NUM   = ETH_DATA_NUM,
  parameter int unsigned ADDR_WIDTH = ETH_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic [15:0]           pkt_sent
);

  localparam int unsigned       LVL_W     = ADDR_WIDTH + 1;
  localparam int unsigned       DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_PKT   = LVL_W'(DATA_NUM);
  localparam logic [LVL_W-1:0]  BEAT_LAST = LVL_W'(DATA_NUM - 1);

  pk_state_e             state, state_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level_n;
  logic [LVL_W-1:0]      beat, beat_n;
  logic                  valid_n, user_n, last_n;
  logic [15:0]           pkt_n;
  logic                  wr_fire, out_fire, rd_en;

  assign wr_fire  = s_axis_tvalid && s_axis_tready;
  assign out_fire = m_axis_tvalid && m_axis_tready;

  // Level counts bytes accepted but not yet handed downstream, including the
  // byte parked in the RAM output register, so the RAM can never be overrun.
  assign level_n = fifo_level + LVL_W'(wr_fire) - LVL_W'(out_fire);

  sdp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (m_axis_tdata)
  );

  // Pointers, occupancy and registered upstream ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_en)   rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      fifo_level    <= level_n;
      s_axis_tready <= (level_n < LVL_FULL);
    end
  end

  // Output FSM state and registered stream sideband.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      beat          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pkt_sent      <= '0;
    end else begin
      state         <= state_n;
      beat          <= beat_n;
      m_axis_tvalid <= valid_n;
      m_axis_tuser  <= user_n;
      m_axis_tlast  <= last_n;
      pkt_sent      <= pkt_n;
    end
  end

  // Next-state, RAM read issue and next sideband values.
  always_comb begin
    state_n = state;
    beat_n  = beat;
    valid_n = m_axis_tvalid;
    user_n  = m_axis_tuser;
    last_n  = m_axis_tlast;
    pkt_n   = pkt_sent;
    rd_en   = 1'b0;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        user_n  = 1'b0;
        last_n  = 1'b0;
        if (fifo_level >= LVL_PKT) state_n = LOAD;
      end
      LOAD: begin
        rd_en   = 1'b1;
        beat_n  = '0;
        valid_n = 1'b1;
        user_n  = 1'b1;
        last_n  = (BEAT_LAST == '0);
        state_n = SEND;
      end
      SEND: begin
        if (m_axis_tready) begin
          if (beat == BEAT_LAST) begin
            state_n = IDLE;
            beat_n  = '0;
            valid_n = 1'b0;
            user_n  = 1'b0;
            last_n  = 1'b0;
            pkt_n   = pkt_sent + 16'd1;
          end else begin
            rd_en   = 1'b1;
            beat_n  = beat + LVL_W'(1);
            user_n  = 1'b0;
            last_n  = ((beat + LVL_W'(1)) == BEAT_LAST);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_udp_packer.sv
// Directed bench for axis_udp_packer with DATA_NUM=8, ADDR_WIDTH=4.
module tb_axis_udp_packer;

  localparam int unsigned DATA_NUM   = 8;
  localparam int unsigned ADDR_WIDTH = 4;

  logic                clk = 1'b0;
  logic                resetn;
  logic [7:0]          s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [7:0]          m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tuser;
  logic                m_axis_tlast;
  logic [ADDR_WIDTH:0] fifo_level;
  logic [15:0]         pkt_sent;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         written, delivered, pkts, out_beat;
  logic [7:0] next_byte, exp_out;
  logic       chk_level;
  logic       seen;

  always #5 clk = ~clk;

  axis_udp_packer #(
    .DATA_NUM   (DATA_NUM),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .fifo_level    (fifo_level),
    .pkt_sent      (pkt_sent)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes completing at this edge, then sample #1 after it.
  task automatic tick();
    logic       in_fire, out_fire, stall, was_last;
    logic [7:0] p_data;
    logic       p_user, p_last;
    in_fire  = s_axis_tvalid && s_axis_tready;
    out_fire = m_axis_tvalid && m_axis_tready;
    stall    = m_axis_tvalid && !m_axis_tready;
    p_data   = m_axis_tdata;
    p_user   = m_axis_tuser;
    p_last   = m_axis_tlast;
    was_last = 1'b0;
    if (out_fire) begin
      check("beat_data",  32'(m_axis_tdata), 32'(exp_out));
      check("beat_tuser", 32'(m_axis_tuser), 32'(out_beat == 0));
      check("beat_tlast", 32'(m_axis_tlast), 32'(out_beat == int'(DATA_NUM) - 1));
      exp_out = exp_out + 8'd1;
      delivered++;
      if (out_beat == int'(DATA_NUM) - 1) begin
        out_beat = 0;
        pkts++;
        was_last = 1'b1;
      end else begin
        out_beat++;
      end
    end
    @(posedge clk);
    #1;
    if (in_fire) begin
      written++;
      next_byte    = next_byte + 8'd1;
      s_axis_tdata = next_byte;
    end
    if (stall) begin
      check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("stall_tdata",  32'(m_axis_tdata),  32'(p_data));
      check("stall_tuser",  32'(m_axis_tuser),  32'(p_user));
      check("stall_tlast",  32'(m_axis_tlast),  32'(p_last));
    end
    if (was_last)      check("post_last_gap", 32'(m_axis_tvalid), 32'd0);
    if (out_beat != 0) check("no_gap_tvalid", 32'(m_axis_tvalid), 32'd1);
    if (chk_level)     check("level_track",   32'(fifo_level), 32'(written - delivered));
  endtask

  task automatic do_reset(input logic [7:0] first_byte);
    resetn = 1'b0;
    #1;
    s_axis_tvalid = 1'b0;
    written   = 0;
    delivered = 0;
    pkts      = 0;
    out_beat  = 0;
    next_byte    = first_byte;
    s_axis_tdata = first_byte;
    exp_out      = first_byte;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic write_bytes(input int n);
    int start;
    start = written;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 100 && written < start + n; i++) tick();
    s_axis_tvalid = 1'b0;
    check("write_count", 32'(written - start), 32'(n));
  endtask

  task automatic wait_pkts(input string tag, input int target, input int bound);
    for (int i = 0; i < bound && pkts < target; i++) tick();
    check(tag, 32'(pkts), 32'(target));
  endtask

  initial begin
    resetn        = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    m_axis_tready = 1'b0;
    next_byte     = 8'h00;
    exp_out       = 8'h00;
    written       = 0;
    delivered     = 0;
    pkts          = 0;
    out_beat      = 0;
    chk_level     = 1'b0;
    seen          = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
    check("rst_tuser",    32'(m_axis_tuser),  32'd0);
    check("rst_tlast",    32'(m_axis_tlast),  32'd0);
    check("rst_tdata",    32'(m_axis_tdata),  32'h00);
    check("rst_level",    32'(fifo_level),    32'd0);
    check("rst_pkt_sent", 32'(pkt_sent),      32'd0);
    resetn = 1'b1;
    tick();
    check("rel_s_tready", 32'(s_axis_tready), 32'd1);

    // Single packet, tready held high, exact valid latency
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    s_axis_tvalid = 1'b0;
    check("t1_written",   32'(written),       32'd8);
    check("t1_level",     32'(fifo_level),    32'd8);
    check("t1_tvalid_c0", 32'(m_axis_tvalid), 32'd0);
    tick();
    check("t1_tvalid_c1", 32'(m_axis_tvalid), 32'd0);
    tick();
    check("t1_tvalid_c2", 32'(m_axis_tvalid), 32'd1);
    check("t1_tuser_c2",  32'(m_axis_tuser),  32'd1);
    check("t1_tlast_c2",  32'(m_axis_tlast),  32'd0);
    check("t1_tdata_c2",  32'(m_axis_tdata),  32'h00);
    for (int i = 0; i < 8; i++) tick();
    check("t1_delivered", 32'(delivered),     32'd8);
    check("t1_tvalid_end",32'(m_axis_tvalid), 32'd0);
    check("t1_pkt_sent",  32'(pkt_sent),      32'd1);
    check("t1_level_end", 32'(fifo_level),    32'd0);

    // Seven bytes never form a packet
    do_reset(8'h00);
    write_bytes(7);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_axis_tvalid) seen = 1'b1;
    end
    check("t2_no_tvalid", 32'(seen),       32'd0);
    check("t2_level",     32'(fifo_level), 32'd7);

    // Fill to full with downstream stalled, then drain two packets
    do_reset(8'h00);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    s_axis_tvalid = 1'b0;
    check("t3_written",   32'(written),       32'd16);
    check("t3_level",     32'(fifo_level),    32'd16);
    check("t3_s_tready",  32'(s_axis_tready), 32'd0);
    check("t3_tvalid",    32'(m_axis_tvalid), 32'd1);
    check("t3_tuser",     32'(m_axis_tuser),  32'd1);
    check("t3_tdata",     32'(m_axis_tdata),  32'h00);
    m_axis_tready = 1'b1;
    wait_pkts("t3_pkts", 2, 60);
    check("t3_pkt_sent",  32'(pkt_sent),      32'd2);
    check("t3_last_byte", 32'(exp_out),       32'h10);
    check("t3_level_end", 32'(fifo_level),    32'd0);
    check("t3_s_tready_end", 32'(s_axis_tready), 32'd1);

    // Random downstream stalls during one packet
    m_axis_tready = 1'b0;
    write_bytes(8);
    for (int i = 0; i < 10 && !m_axis_tvalid; i++) tick();
    check("t4_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("t4_tdata",  32'(m_axis_tdata),  32'h10);
    for (int i = 0; i < 300 && pkts < 3; i++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
    end
    check("t4_pkts",      32'(pkts),      32'd3);
    check("t4_pkt_sent",  32'(pkt_sent),  32'd3);
    check("t4_delivered", 32'(delivered), 32'd24);

    // Streaming 40 bytes with concurrent read/write and pointer wrap
    m_axis_tready = 1'b1;
    chk_level     = 1'b1;
    write_bytes(40);
    wait_pkts("t5_pkts", 8, 200);
    chk_level     = 1'b0;
    check("t5_pkt_sent",  32'(pkt_sent),   32'd8);
    check("t5_delivered", 32'(delivered),  32'd64);
    check("t5_next_exp",  32'(exp_out),    32'h40);
    check("t5_level_end", 32'(fifo_level), 32'd0);

    // Reset at beat 3 abandons the packet
    write_bytes(8);
    for (int i = 0; i < 30 && out_beat != 3; i++) tick();
    check("t6_at_beat3",  32'(out_beat),     32'd3);
    check("t6_tdata_b3",  32'(m_axis_tdata), 32'h43);
    resetn = 1'b0;
    #1;
    check("t6_rst_tvalid",   32'(m_axis_tvalid), 32'd0);
    check("t6_rst_tuser",    32'(m_axis_tuser),  32'd0);
    check("t6_rst_tlast",    32'(m_axis_tlast),  32'd0);
    check("t6_rst_tdata",    32'(m_axis_tdata),  32'h00);
    check("t6_rst_level",    32'(fifo_level),    32'd0);
    check("t6_rst_pkt_sent", 32'(pkt_sent),      32'd0);
    check("t6_rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("t6_no_extra_pkt", 32'(pkts),          32'd8);
    do_reset(8'hA0);
    check("t6_rel_s_tready", 32'(s_axis_tready), 32'd1);
    write_bytes(8);
    for (int i = 0; i < 10 && !m_axis_tvalid; i++) tick();
    check("t6_new_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("t6_new_tuser",  32'(m_axis_tuser),  32'd1);
    check("t6_new_tdata",  32'(m_axis_tdata),  32'hA0);
    wait_pkts("t6_pkts", 1, 30);
    check("t6_pkt_sent",   32'(pkt_sent),      32'd1);
    check("t6_level_end",  32'(fifo_level),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
